sprite_v4: RTL and testbench

SPRITE_V4 -- requirements
Module: sprite_v4

---
 rtl/sprite_v4.sv | 164 ++++++++++++++++
 tb/tb_sprite_v4.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_v4.sv
// Scan-line sprite engine: draws a WIDTHxHEIGHT palette-index graphic, scaled by
// SCALE_X/SCALE_Y and optionally mirrored, at a screen position latched each frame.
module sprite_v4 #(
   parameter int    WIDTH       = 8,
   parameter int    HEIGHT      = 8,
   parameter int    SCALE_X     = 1,
   parameter int    SCALE_Y     = 1,
   parameter int    COLR_BITS   = 4,
   parameter int    TRANS_INDEX = 0,
   parameter string SPR_FILE    = "",
   parameter int    CORDW       = 10,
   parameter int    H_RES_FULL  = 800,
   parameter int    DEPTH       = WIDTH*HEIGHT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame,
   input  logic                 line,
   input  logic [CORDW-1:0]     sx,
   input  logic [CORDW-1:0]     sy,
   input  logic [CORDW-1:0]     sprx,
   input  logic [CORDW-1:0]     spry,
   input  logic                 flip_x,
   output logic [COLR_BITS-1:0] pix,
   output logic                 drawing,
   output logic                 done
);

   localparam int OXW = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
   localparam int OYW = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
   localparam int CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int CYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
   localparam int AW  = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;

   typedef enum logic [2:0] {
      IDLE, WAIT_LINE, LINE_INIT, AWAIT_POS, DRAW, NEXT_LINE, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CORDW-1:0]     sprx_q, sprx_d, spry_q, spry_d;
   logic                 flip_q, flip_d;
   logic [OXW-1:0]       ox_q, ox_d;
   logic [CXW-1:0]       cx_q, cx_d;
   logic [OYW-1:0]       oy_q, oy_d;
   logic [CYW-1:0]       cy_q, cy_d;
   logic [AW-1:0]        base_q, base_d;
   logic [AW-1:0]        addr;
   logic [CORDW-1:0]     start_x;
   logic                 col_step, last_col, last_row;
   logic                 rd_valid_q, rd_valid_d;
   logic [COLR_BITS-1:0] rd_word_q;
   logic [COLR_BITS-1:0] mem [DEPTH];

   // Address goes out two cycles before the column is shown: one cycle to enter
   // DRAW, one cycle of memory latency, hence the match on sprx-2.
   always_comb begin
      start_x  = (sprx_q >= CORDW'(2)) ? sprx_q - CORDW'(2)
                                       : sprx_q + CORDW'(H_RES_FULL - 2);
      col_step = (cx_q == CXW'(SCALE_X - 1));
      last_col = (ox_q == OXW'(WIDTH - 1)) && col_step;
      last_row = (oy_q == OYW'(HEIGHT - 1)) && (cy_q == CYW'(SCALE_Y - 1));
      addr     = flip_q ? base_q + AW'(WIDTH - 1) - AW'(ox_q) : base_q + AW'(ox_q);
   end

   always_comb begin
      state_d    = state_q;
      sprx_d     = sprx_q;
      spry_d     = spry_q;
      flip_d     = flip_q;
      ox_d       = ox_q;
      cx_d       = cx_q;
      oy_d       = oy_q;
      cy_d       = cy_q;
      base_d     = base_q;
      rd_valid_d = 1'b0;
      case (state_q)
         IDLE: ;
         WAIT_LINE: begin
            if (line && (sy == spry_q)) begin
               state_d = LINE_INIT;
               oy_d    = '0;
               cy_d    = '0;
               base_d  = '0;
            end
         end
         LINE_INIT: begin
            state_d = AWAIT_POS;
            ox_d    = '0;
            cx_d    = '0;
         end
         AWAIT_POS: begin
            if (sx == start_x) state_d = DRAW;
         end
         DRAW: begin
            rd_valid_d = 1'b1;
            if (col_step) begin
               cx_d = '0;
               ox_d = ox_q + OXW'(1);
            end else begin
               cx_d = cx_q + CXW'(1);
            end
            if (last_col) begin
               ox_d    = '0;
               state_d = last_row ? DONE : NEXT_LINE;
            end
         end
         NEXT_LINE: begin
            if (line) begin
               state_d = AWAIT_POS;
               if (cy_q == CYW'(SCALE_Y - 1)) begin
                  cy_d   = '0;
                  oy_d   = oy_q + OYW'(1);
                  base_d = base_q + AW'(WIDTH);
               end else begin
                  cy_d = cy_q + CYW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A frame pulse restarts from any state and cancels the word in flight.
      if (frame) begin
         state_d    = WAIT_LINE;
         sprx_d     = sprx;
         spry_d     = spry;
         flip_d     = flip_x;
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sprx_q     <= '0;
         spry_q     <= '0;
         flip_q     <= 1'b0;
         ox_q       <= '0;
         cx_q       <= '0;
         oy_q       <= '0;
         cy_q       <= '0;
         base_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sprx_q     <= sprx_d;
         spry_q     <= spry_d;
         flip_q     <= flip_d;
         ox_q       <= ox_d;
         cx_q       <= cx_d;
         oy_q       <= oy_d;
         cy_q       <= cy_d;
         base_q     <= base_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) rd_word_q <= mem[addr];

   assign drawing = rd_valid_q && (rd_word_q != COLR_BITS'(TRANS_INDEX));
   assign pix     = drawing ? rd_word_q : '0;
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sprite_v4.sv
// Bench for sprite_v4: an unscaled 800-wide instance and a 2x3-scaled 200-wide
// instance, checked cycle by cycle against a position/timing model of the sprite.
module tb_sprite_v4;

   localparam int SPR_W = 8;
   localparam int SPR_H = 8;
   localparam int CW    = 4;
   localparam int CORDW = 10;
   localparam int H1    = 800;
   localparam int H2    = 200;
   localparam int SX2   = 2;
   localparam int SY2   = 3;
   localparam int MAXC  = 10000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             frame1 = 1'b0, frame2 = 1'b0;
   logic             line = 1'b0;
   logic             flip = 1'b0;
   logic [CORDW-1:0] sx = '0, sy = '0, sprx = '0, spry = '0;
   logic [CW-1:0]    pix1, pix2;
   logic             drawing1, drawing2, done1, done2;

   logic [CW-1:0]    img [SPR_W*SPR_H];
   logic [CW-1:0]    exp_pix [MAXC];
   logic             exp_drw [MAXC];
   logic             exp_done [MAXC];
   int               checks = 0;
   int               failures = 0;

   typedef struct {
      int sel; int px; int py; int fl; int sy0; int nlines;
      int first_sx; int first_pix; int opaque; int dones;
   } vec_t;
   vec_t vecs [5];

   sprite_v4 dut1 (
      .clk(clk), .rst(rst), .frame(frame1), .line(line), .sx(sx), .sy(sy),
      .sprx(sprx), .spry(spry), .flip_x(flip),
      .pix(pix1), .drawing(drawing1), .done(done1)
   );

   sprite_v4 #(.SCALE_X(SX2), .SCALE_Y(SY2), .H_RES_FULL(H2)) dut2 (
      .clk(clk), .rst(rst), .frame(frame2), .line(line), .sx(sx), .sy(sy),
      .sprx(sprx), .spry(spry), .flip_x(flip),
      .pix(pix2), .drawing(drawing2), .done(done2)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic load_mems();
      for (int i = 0; i < SPR_W*SPR_H; i++) begin
         dut1.mem[i] = img[i];
         dut2.mem[i] = img[i];
      end
   endtask

   // Frame timing: frame at cycle -1, line pulse at every sx=0 (cycle t, t%hres==0).
   // Sprite line k starts seeking at line+2 (first) or line+1 (later lines), finds
   // sx==sprx-2, shows pixels 2 cycles later; next line pulse is the first one after
   // the line finished.
   task automatic build_model(input int px, input int py, input int fl, input int sy0,
                              input int hres, input int scx, input int scy);
      int a, seek, tgt, c, last_c, row, col;
      logic [CW-1:0] v;
      for (int t = 0; t < MAXC; t++) begin
         exp_pix[t] = '0; exp_drw[t] = 1'b0; exp_done[t] = 1'b0;
      end
      a   = (py - sy0) * hres;
      tgt = (px >= 2) ? px - 2 : px + hres - 2;
      for (int k = 0; k < SPR_H*scy; k++) begin
         seek = a + ((k == 0) ? 2 : 1);
         c    = seek + ((tgt - (seek % hres)) + hres) % hres;
         row  = k / scy;
         for (int j = 0; j < SPR_W*scx; j++) begin
            col = j / scx;
            if (fl != 0) col = SPR_W - 1 - col;
            v = img[row*SPR_W + col];
            if ((c + 2 + j < MAXC) && (v != 0)) begin
               exp_pix[c+2+j] = v;
               exp_drw[c+2+j] = 1'b1;
            end
         end
         last_c = c + SPR_W*scx;
         if (k == SPR_H*scy - 1) begin
            if (last_c + 1 < MAXC) exp_done[last_c+1] = 1'b1;
         end else begin
            a = ((last_c + hres) / hres) * hres;
         end
      end
   endtask

   // driver: one frame of nlines screen lines on the selected instance
   task automatic run_frame(input int sel, input int px, input int py, input int fl,
                            input int sy0, input int nlines,
                            output int n_op, output int n_done,
                            output int f_sx, output int f_pix);
      int hres, act, req;
      hres = (sel != 0) ? H2 : H1;
      build_model(px, py, fl, sy0, hres, (sel != 0) ? SX2 : 1, (sel != 0) ? SY2 : 1);
      n_op = 0; n_done = 0; f_sx = -1; f_pix = -1;
      @(posedge clk); #1;
      sprx = CORDW'(px); spry = CORDW'(py); flip = fl[0];
      sx = CORDW'(hres - 1); line = 1'b0;
      frame1 = (sel == 0); frame2 = (sel != 0);
      @(posedge clk); #1;
      frame1 = 1'b0; frame2 = 1'b0;
      // scramble inputs: the latched values must govern the frame
      sprx = CORDW'($urandom_range(0, H2-1));
      spry = CORDW'($urandom_range(0, 63));
      flip = ~flip;
      for (int t = 0; t < nlines*hres; t++) begin
         sx   = CORDW'(t % hres);
         sy   = CORDW'(sy0 + t / hres);
         line = (t % hres == 0);
         @(negedge clk);
         if (sel != 0) act = int'({drawing2, done2, pix2});
         else          act = int'({drawing1, done1, pix1});
         req = int'({exp_drw[t], exp_done[t], exp_pix[t]});
         check($sformatf("pixel sel=%0d t=%0d", sel, t), act, req);
         if (act[5]) begin
            n_op++;
            if (f_sx < 0) begin f_sx = t % hres; f_pix = act & 15; end
         end
         if (act[4]) n_done++;
         @(posedge clk); #1;
      end
      line = 1'b0;
   endtask

   initial begin
      int n_op, n_done, f_sx, f_pix, seen, cnt, act;

      // {sel, sprx, spry, flip, sy0, nlines, first_sx, first_pix, opaque, dones}
      vecs[0] = '{0, 100, 50, 0, 49,  9, 100, 1,  61, 1};
      vecs[1] = '{0, 100, 50, 1, 49,  9, 100, 8,  61, 1};
      vecs[2] = '{0,   0, 20, 0, 19,  5,   0, 1,  16, 0};
      vecs[3] = '{0,   1, 20, 0, 19,  5,   1, 1,  16, 0};
      vecs[4] = '{1, 100, 50, 0, 49, 26, 100, 1, 366, 1};

      // row 0 = 1..8; other rows (3r+c)%16, transparent at (3,7) (4,4) (5,1)
      for (int r = 0; r < SPR_H; r++)
         for (int c = 0; c < SPR_W; c++)
            img[r*SPR_W + c] = (r == 0) ? CW'(c + 1) : CW'((3*r + c) % 16);

      // reset
      #1 rst = 1'b1;
      @(posedge clk); #2;
      check("reset_dut1", int'({drawing1, done1, pix1}), 0);
      check("reset_dut2", int'({drawing2, done2, pix2}), 0);
      load_mems();
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i].sel, vecs[i].px, vecs[i].py, vecs[i].fl, vecs[i].sy0,
                   vecs[i].nlines, n_op, n_done, f_sx, f_pix);
         check($sformatf("vec%0d_first_sx", i),  f_sx,   vecs[i].first_sx);
         check($sformatf("vec%0d_first_pix", i), f_pix,  vecs[i].first_pix);
         check($sformatf("vec%0d_opaque", i),    n_op,   vecs[i].opaque);
         check($sformatf("vec%0d_done", i),      n_done, vecs[i].dones);
      end

      // asynchronous reset in the middle of a drawn line
      @(posedge clk); #1;
      sprx = 10'd40; spry = 10'd5; flip = 1'b0; sx = CORDW'(H2 - 1); frame2 = 1'b1;
      @(posedge clk); #1;
      frame2 = 1'b0;
      seen = 0;
      for (int t = 0; t < 4*H2 && seen == 0; t++) begin
         sx = CORDW'(t % H2); sy = CORDW'(4 + t / H2); line = (t % H2 == 0);
         @(negedge clk);
         if (drawing2) seen = 1;
         else begin @(posedge clk); #1; end
      end
      check("rst_reach_draw", seen, 1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_out", int'({drawing2, done2, pix2}), 0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      line = 1'b0;

      // no drawing after reset release without a frame pulse
      cnt = 0;
      for (int t = 0; t < 3*H2; t++) begin
         sx = CORDW'(t % H2); sy = '0; line = (t % H2 == 0);
         @(negedge clk);
         if (drawing1 || drawing2 || done1 || done2) cnt++;
         @(posedge clk); #1;
      end
      line = 1'b0;
      check("idle_after_reset", cnt, 0);

      run_frame(1, 60, 10, 1, 9, 26, n_op, n_done, f_sx, f_pix);
      check("post_rst_opaque", n_op, 366);
      check("post_rst_done", n_done, 1);

      // randomized images and positions on the scaled instance
      for (int r = 0; r < 3; r++) begin
         int px, py, fl;
         for (int i = 0; i < SPR_W*SPR_H; i++) img[i] = CW'($urandom_range(0, 15));
         load_mems();
         px = $urandom_range(4, 180);
         py = $urandom_range(1, 50);
         fl = $urandom_range(0, 1);
         run_frame(1, px, py, fl, py - 1, 26, n_op, n_done, f_sx, f_pix);
         check($sformatf("rand%0d_done", r), n_done, 1);
      end

      act = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
